vec_wb_stage: RTL and testbench

- Writeback stage directly downstream of the vector execute stage.
- Captures the full-width result and destination register whenever execute pulses done.
- Streams the result into the vector register file write port, LANES elements per beat, over VLEN/LANES beats.
- Holds one pending result so execute is not blocked during a writeback; reports busy, completion and overrun.

---
 rtl/vec_wb_if.sv | 35 +++
 rtl/vec_wb_stage.sv | 151 +++++++++++++++
 tb/tb_vec_wb_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vec_wb_if.sv
// Execute-result input, register-file write port and status signals of the
// vector writeback stage.
interface vec_wb_if #(
  parameter int unsigned VLEN   = 8,
  parameter int unsigned EWIDTH = 32,
  parameter int unsigned LANES  = 2,
  parameter int unsigned BEAT_W = 2
);
  localparam int unsigned DATA_W = EWIDTH * VLEN;
  localparam int unsigned BDW    = EWIDTH * LANES;

  logic              ex_done;
  logic [DATA_W-1:0] ex_result;
  logic [4:0]        ex_vd;
  logic              vrf_ready;
  logic              vrf_we;
  logic [4:0]        vrf_waddr;
  logic [BEAT_W-1:0] vrf_wbeat;
  logic [BDW-1:0]    vrf_wdata;
  logic              wb_busy;
  logic              wb_done;
  logic              wb_overrun;

  // Execute stage plus register file side.
  modport master (
    output ex_done, ex_result, ex_vd, vrf_ready,
    input  vrf_we, vrf_waddr, vrf_wbeat, vrf_wdata, wb_busy, wb_done, wb_overrun
  );

  // Writeback stage side.
  modport slave (
    input  ex_done, ex_result, ex_vd, vrf_ready,
    output vrf_we, vrf_waddr, vrf_wbeat, vrf_wdata, wb_busy, wb_done, wb_overrun
  );
endinterface

// File: rtl/vec_wb_stage.sv
// Vector writeback stage: captures execute results (one active, one pending)
// and streams them into the register file LANES elements per beat.
module vec_wb_stage #(
  parameter int unsigned VLEN   = 8,
  parameter int unsigned EWIDTH = 32,
  parameter int unsigned LANES  = 2,
  parameter int unsigned BEAT_W = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  vec_wb_if.slave bus
);

  localparam int unsigned NBEATS = VLEN / LANES;
  localparam int unsigned DATA_W = EWIDTH * VLEN;
  localparam int unsigned BDW    = EWIDTH * LANES;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef enum logic {IDLE, WRITE} state_t;
  typedef logic [NBEATS-1:0][BDW-1:0] beats_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] act_data_q, act_data_d;
  logic [4:0]        act_vd_q, act_vd_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [4:0]        pend_vd_q, pend_vd_d;
  logic              pend_valid_q, pend_valid_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              overrun_q, overrun_d;
  logic              done_d;

  logic              we_q;
  logic [4:0]        waddr_q;
  logic [BEAT_W-1:0] wbeat_q;
  logic [BDW-1:0]    wdata_q;
  logic              busy_q;
  logic              done_q;

  logic   accept;
  logic   last_accept;
  beats_t act_beats_d;

  // Next-state, buffer management and handshake decode.
  always_comb begin
    state_d      = state_q;
    act_data_d   = act_data_q;
    act_vd_d     = act_vd_q;
    pend_data_d  = pend_data_q;
    pend_vd_d    = pend_vd_q;
    pend_valid_d = pend_valid_q;
    beat_d       = beat_q;
    overrun_d    = overrun_q;
    done_d       = 1'b0;

    accept      = (state_q == WRITE) && bus.vrf_ready;
    last_accept = accept && (beat_q == LAST_BEAT);

    case (state_q)
      IDLE: begin
        if (bus.ex_done) begin
          act_data_d = bus.ex_result;
          act_vd_d   = bus.ex_vd;
          beat_d     = '0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (last_accept) begin
          done_d = 1'b1;
          beat_d = '0;
          if (pend_valid_q) begin
            // Pending promotes; a same-cycle input refills pending, so no overrun.
            act_data_d = pend_data_q;
            act_vd_d   = pend_vd_q;
            if (bus.ex_done) begin
              pend_data_d = bus.ex_result;
              pend_vd_d   = bus.ex_vd;
            end else begin
              pend_valid_d = 1'b0;
            end
          end else if (bus.ex_done) begin
            act_data_d = bus.ex_result;
            act_vd_d   = bus.ex_vd;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (accept) begin
            beat_d = beat_q + BEAT_W'(1);
          end
          if (bus.ex_done) begin
            if (!pend_valid_q) begin
              pend_data_d  = bus.ex_result;
              pend_vd_d    = bus.ex_vd;
              pend_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    act_beats_d = beats_t'(act_data_d);
  end

  // State, buffers and registered outputs (outputs track the next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      act_data_q   <= '0;
      act_vd_q     <= '0;
      pend_data_q  <= '0;
      pend_vd_q    <= '0;
      pend_valid_q <= 1'b0;
      beat_q       <= '0;
      overrun_q    <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wbeat_q      <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_data_q   <= act_data_d;
      act_vd_q     <= act_vd_d;
      pend_data_q  <= pend_data_d;
      pend_vd_q    <= pend_vd_d;
      pend_valid_q <= pend_valid_d;
      beat_q       <= beat_d;
      overrun_q    <= overrun_d;
      we_q         <= (state_d == WRITE);
      waddr_q      <= act_vd_d;
      wbeat_q      <= beat_d;
      wdata_q      <= act_beats_d[beat_d];
      busy_q       <= (state_d == WRITE) || pend_valid_d;
      done_q       <= done_d;
    end
  end

  assign bus.vrf_we     = we_q;
  assign bus.vrf_waddr  = waddr_q;
  assign bus.vrf_wbeat  = wbeat_q;
  assign bus.vrf_wdata  = wdata_q;
  assign bus.wb_busy    = busy_q;
  assign bus.wb_done    = done_q;
  assign bus.wb_overrun = overrun_q;

endmodule

// File: tb/tb_vec_wb_stage.sv
// Directed per-cycle vector tables for vec_wb_stage plus a reset-mid-write sequence.
module tb_vec_wb_stage;

  localparam int unsigned VLEN   = 8;
  localparam int unsigned EWIDTH = 32;
  localparam int unsigned LANES  = 2;
  localparam int unsigned BEAT_W = 2;
  localparam int unsigned BDW    = EWIDTH * LANES;

  logic clk;
  logic rst_n;

  vec_wb_if #(.VLEN(VLEN), .EWIDTH(EWIDTH), .LANES(LANES), .BEAT_W(BEAT_W)) bus ();

  vec_wb_stage #(.VLEN(VLEN), .EWIDTH(EWIDTH), .LANES(LANES), .BEAT_W(BEAT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per clock cycle: inputs driven in that cycle, outputs expected in it.
  typedef struct {
    bit          exd;
    logic [4:0]  evd;
    int unsigned ebase;
    bit          rdy;
    bit          we;
    logic [4:0]  vd;
    int unsigned bt;
    int unsigned wbase;
    bit          dn;
    bit          bs;
    bit          ov;
  } vec_t;

  vec_t tab1[$];
  vec_t tab2[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t r(bit exd, logic [4:0] evd, int unsigned ebase, bit rdy,
                             bit we, logic [4:0] vd, int unsigned bt, int unsigned wbase,
                             bit dn, bit bs, bit ov);
    vec_t v;
    v.exd = exd; v.evd = evd; v.ebase = ebase; v.rdy = rdy;
    v.we = we; v.vd = vd; v.bt = bt; v.wbase = wbase;
    v.dn = dn; v.bs = bs; v.ov = ov;
    return v;
  endfunction

  // Element i of a vector with base b holds b+i.
  function automatic logic [BDW-1:0] beat_data(int unsigned wbase, int unsigned bt);
    logic [BDW-1:0] d;
    for (int l = 0; l < int'(LANES); l++)
      d[EWIDTH*l +: EWIDTH] = EWIDTH'(wbase + bt * LANES + l);
    return d;
  endfunction

  task automatic drive(bit exd, logic [4:0] evd, int unsigned ebase, bit rdy);
    logic [EWIDTH*VLEN-1:0] res;
    for (int i = 0; i < int'(VLEN); i++)
      res[EWIDTH*i +: EWIDTH] = EWIDTH'(ebase + i);
    bus.ex_done   = exd;
    bus.ex_vd     = evd;
    bus.ex_result = res;
    bus.vrf_ready = rdy;
  endtask

  task automatic check_status(string name, bit we, bit dn, bit bs, bit ov);
    logic [3:0] act, exp;
    act = {bus.vrf_we, bus.wb_done, bus.wb_busy, bus.wb_overrun};
    exp = {we, dn, bs, ov};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s status{we,done,busy,ovr} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_beat(string name, logic [4:0] vd, int unsigned bt, int unsigned wbase);
    logic [5+BEAT_W+BDW-1:0] act, exp;
    act = {bus.vrf_waddr, bus.vrf_wbeat, bus.vrf_wdata};
    exp = {vd, BEAT_W'(bt), beat_data(wbase, bt)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s beat{addr,beat,data} got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(string tname, input vec_t tab[$]);
    for (int i = 0; i < tab.size(); i++) begin
      string nm;
      nm = $sformatf("%s_row%0d", tname, i);
      drive(tab[i].exd, tab[i].evd, tab[i].ebase, tab[i].rdy);
      check_status(nm, tab[i].we, tab[i].dn, tab[i].bs, tab[i].ov);
      if (tab[i].we) check_beat(nm, tab[i].vd, tab[i].bt, tab[i].wbase);
      step();
    end
  endtask

  initial begin
    // Single vector: vd3 at 0x100, done at T+5.
    tab1.push_back(r(1, 3, 'h100, 1,  0, 0, 0, 0,      0, 0, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 0, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 1, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 2, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 3, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  0, 0, 0, 0,      1, 0, 0));
    tab1.push_back(r(0, 0, 0,     1,  0, 0, 0, 0,      0, 0, 0));
    // Backpressure: beat 1 held three cycles, done at T+8.
    tab1.push_back(r(1, 3, 'h100, 1,  0, 0, 0, 0,      0, 0, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 0, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     0,  1, 3, 1, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     0,  1, 3, 1, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     0,  1, 3, 1, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 1, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 2, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 3, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  0, 0, 0, 0,      1, 0, 0));
    tab1.push_back(r(0, 0, 0,     1,  0, 0, 0, 0,      0, 0, 0));
    // Pending: vd7 at T+2, beats follow without a gap, done at T+5 and T+9.
    tab1.push_back(r(1, 3, 'h100, 1,  0, 0, 0, 0,      0, 0, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 0, 'h100,  0, 1, 0));
    tab1.push_back(r(1, 7, 'h200, 1,  1, 3, 1, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 2, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 3, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 7, 0, 'h200,  1, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 7, 1, 'h200,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 7, 2, 'h200,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 7, 3, 'h200,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  0, 0, 0, 0,      1, 0, 0));
    // Overrun: inputs at T, T+1, T+2; third dropped, overrun from T+3.
    tab1.push_back(r(1, 3, 'h100, 1,  0, 0, 0, 0,      0, 0, 0));
    tab1.push_back(r(1, 7, 'h200, 1,  1, 3, 0, 'h100,  0, 1, 0));
    tab1.push_back(r(1, 9, 'h300, 1,  1, 3, 1, 'h100,  0, 1, 0));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 2, 'h100,  0, 1, 1));
    tab1.push_back(r(0, 0, 0,     1,  1, 3, 3, 'h100,  0, 1, 1));
    tab1.push_back(r(0, 0, 0,     1,  1, 7, 0, 'h200,  1, 1, 1));
    tab1.push_back(r(0, 0, 0,     1,  1, 7, 1, 'h200,  0, 1, 1));
    tab1.push_back(r(0, 0, 0,     1,  1, 7, 2, 'h200,  0, 1, 1));
    tab1.push_back(r(0, 0, 0,     1,  1, 7, 3, 'h200,  0, 1, 1));
    tab1.push_back(r(0, 0, 0,     1,  0, 0, 0, 0,      1, 0, 1));
    tab1.push_back(r(0, 0, 0,     1,  0, 0, 0, 0,      0, 0, 1));

    // Same-cycle edge: pending full and ex_done on the last-beat accept.
    tab2.push_back(r(1, 3, 'h100, 1,  0, 0, 0, 0,      0, 0, 0));
    tab2.push_back(r(1, 7, 'h200, 1,  1, 3, 0, 'h100,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 3, 1, 'h100,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 3, 2, 'h100,  0, 1, 0));
    tab2.push_back(r(1, 9, 'h300, 1,  1, 3, 3, 'h100,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 7, 0, 'h200,  1, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 7, 1, 'h200,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 7, 2, 'h200,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 7, 3, 'h200,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 9, 0, 'h300,  1, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 9, 1, 'h300,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 9, 2, 'h300,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 9, 3, 'h300,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  0, 0, 0, 0,      1, 0, 0));
    tab2.push_back(r(0, 0, 0,     1,  0, 0, 0, 0,      0, 0, 0));
    // ex_done on the last-beat accept with pending empty goes straight to active.
    tab2.push_back(r(1, 3, 'h100, 1,  0, 0, 0, 0,      0, 0, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 3, 0, 'h100,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 3, 1, 'h100,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 3, 2, 'h100,  0, 1, 0));
    tab2.push_back(r(1, 7, 'h200, 1,  1, 3, 3, 'h100,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 7, 0, 'h200,  1, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 7, 1, 'h200,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 7, 2, 'h200,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  1, 7, 3, 'h200,  0, 1, 0));
    tab2.push_back(r(0, 0, 0,     1,  0, 0, 0, 0,      1, 0, 0));

    rst_n = 1'b0;
    drive(0, 0, 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_status("reset_state", 0, 0, 0, 0);

    run_table("t1", tab1);

    // Reset during beat 2 of a fresh vector while overrun is still set.
    drive(1, 3, 'h100, 1);
    check_status("pre_reset_ovr", 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 1);
    step();
    step();
    check_beat("pre_reset_beat2", 3, 2, 'h100);
    rst_n = 1'b0;
    #1;
    check_status("reset_mid_write", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check_status($sformatf("post_reset_idle%0d", i), 0, 0, 0, 0);
      step();
    end

    run_table("t2", tab2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
